// File: rtl/fetch_if.sv
// fetch_if: groups the Fetch stage's hazard, redirect, memory and Decode-side
// signals. The master modport is the Fetch stage. The slave modport is its
// environment: the hazard unit, Execute, instruction memory and Decode.
interface fetch_if;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        BranchTakenE;
    logic [31:0] BranchTargetE;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic [31:0] InstrD;
    logic [31:0] PcD;
    logic [31:0] PcPlus8D;
    logic        ValidD;
    logic [31:0] FetchCount;
    logic [31:0] StallCount;

    modport master (
        input  StallF, StallD, FlushD, BranchTakenE, BranchTargetE, InstrF,
        output PCF, InstrD, PcD, PcPlus8D, ValidD, FetchCount, StallCount
    );

    modport slave (
        output StallF, StallD, FlushD, BranchTakenE, BranchTargetE, InstrF,
        input  PCF, InstrD, PcD, PcPlus8D, ValidD, FetchCount, StallCount
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register and Fetch->Decode pipeline register of the simple
// pipelined ARM core. It honours hazard stall/flush and branch redirect from
// Execute.
// Optional performance counters are enabled with the macro FETCH_PERF_CNT_EN.
// When the macro is undefined, FetchCount and StallCount read as 0 and no
// counter flops are built.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic   clk,
    input  logic   reset,
    fetch_if.master bus
);

    logic [31:0] pc_q,       pc_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] pcd_q,      pcd_d;
    logic [31:0] pcplus8_q,  pcplus8_d;
    logic        valid_q,    valid_d;
    logic        load_fd;

    // Target alignment bits are architecturally ignored.
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^bus.BranchTargetE[1:0];

    // Next PC: a redirect beats a stall, otherwise advance sequentially (mod 2^32).
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (bus.BranchTakenE) begin
            pc_d = {bus.BranchTargetE[31:2], 2'b00};
        end else if (bus.StallF) begin
            pc_d = pc_q;
        end
    end

    // Next Fetch->Decode contents: a flush or redirect inserts a bubble and wins
    // over StallD. On a bubble, PcD and PcPlus8D keep their old values.
    always_comb begin
        instr_d   = instr_q;
        pcd_d     = pcd_q;
        pcplus8_d = pcplus8_q;
        valid_d   = valid_q;
        load_fd   = 1'b0;
        if (bus.FlushD || bus.BranchTakenE) begin
            instr_d = 32'h0;
            valid_d = 1'b0;
        end else if (!bus.StallD) begin
            load_fd   = 1'b1;
            instr_d   = bus.InstrF;
            pcd_d     = pc_q;
            pcplus8_d = pc_q + 32'd8;
            valid_d   = 1'b1;
        end
    end

    // PC register and Fetch->Decode register state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            pcd_q     <= 32'h0;
            pcplus8_q <= 32'h0;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcd_q     <= pcd_d;
            pcplus8_q <= pcplus8_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.PCF      = pc_q;
    assign bus.InstrD   = instr_q;
    assign bus.PcD      = pcd_q;
    assign bus.PcPlus8D = pcplus8_q;
    assign bus.ValidD   = valid_q;

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counter next state: count real loads into Decode, and count non-redirected
    // StallF cycles. Both counters saturate.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (load_fd) begin
            fetch_cnt_d = sat_inc(fetch_cnt_q);
        end
        if (bus.StallF && !bus.BranchTakenE) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    // Performance counter registers; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.FetchCount = fetch_cnt_q;
    assign bus.StallCount = stall_cnt_q;
`else
    logic unused_load_fd;
    assign unused_load_fd = load_fd;

    assign bus.FetchCount = 32'h0;
    assign bus.StallCount = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage. The instruction memory
// returns (address | 32'hE000_0000). A second instance with
// RESET_PC = 32'hFFFF_FFF8 exercises PC wrap-around.
module tb_fetch_stage;

    logic clk;
    logic reset;
    logic rst2_n;
    int   n_tests;
    int   n_fail;

    fetch_if bus ();
    fetch_if bus2 ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk   (clk),
        .reset (rst2_n),
        .bus   (bus2)
    );

    assign bus.InstrF  = bus.PCF  | 32'hE000_0000;
    assign bus2.InstrF = bus2.PCF | 32'hE000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.StallF = 0; bus.StallD = 0; bus.FlushD = 0;
        bus.BranchTakenE = 0; bus.BranchTargetE = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        #12;
        n_tests++; if (bus.PCF !== 32'h0) begin n_fail++; $display("FAIL rst_pcf got %h exp %h", bus.PCF, 32'h0); end
        n_tests++; if (bus.InstrD !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h exp %h", bus.InstrD, 32'h0); end
        n_tests++; if (bus.PcD !== 32'h0 || bus.PcPlus8D !== 32'h0) begin n_fail++; $display("FAIL rst_pcd got %h/%h exp 0/0", bus.PcD, bus.PcPlus8D); end
        n_tests++; if (bus.ValidD !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", bus.ValidD); end
        n_tests++; if (bus.FetchCount !== 32'h0 || bus.StallCount !== 32'h0) begin n_fail++; $display("FAIL rst_cnt got %h/%h exp 0/0", bus.FetchCount, bus.StallCount); end
        @(negedge clk);
        reset = 1'b1;
        step();
        n_tests++; if (bus.PCF !== 32'h4) begin n_fail++; $display("FAIL run1_pcf got %h exp %h", bus.PCF, 32'h4); end
        n_tests++; if (bus.InstrD !== 32'hE000_0000) begin n_fail++; $display("FAIL run1_instr got %h exp %h", bus.InstrD, 32'hE000_0000); end
        n_tests++; if (bus.PcD !== 32'h0 || bus.PcPlus8D !== 32'h8) begin n_fail++; $display("FAIL run1_pcd got %h/%h exp 0/8", bus.PcD, bus.PcPlus8D); end
        n_tests++; if (bus.ValidD !== 1'b1) begin n_fail++; $display("FAIL run1_valid got %b exp 1", bus.ValidD); end
        step();
        n_tests++; if (bus.PCF !== 32'h8 || bus.InstrD !== 32'hE000_0004 || bus.PcD !== 32'h4) begin n_fail++; $display("FAIL run2 got pcf %h instr %h pcd %h exp 8/E0000004/4", bus.PCF, bus.InstrD, bus.PcD); end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        do_reset();
        for (int i = 0; i < 16; i++) step();
        n_tests++; if (bus.PCF !== 32'h40 || bus.ValidD !== 1'b1) begin n_fail++; $display("FAIL pre_async got pcf %h valid %b exp 40/1", bus.PCF, bus.ValidD); end
        #2;
        reset = 1'b0;
        #1;
        n_tests++; if (bus.PCF !== 32'h0) begin n_fail++; $display("FAIL async_pcf got %h exp %h", bus.PCF, 32'h0); end
        n_tests++; if (bus.ValidD !== 1'b0 || bus.InstrD !== 32'h0) begin n_fail++; $display("FAIL async_fd got valid %b instr %h exp 0/0", bus.ValidD, bus.InstrD); end
        n_tests++; if (bus.PcD !== 32'h0 || bus.PcPlus8D !== 32'h0 || bus.FetchCount !== 32'h0) begin n_fail++; $display("FAIL async_pcd got %h/%h cnt %h exp 0/0/0", bus.PcD, bus.PcPlus8D, bus.FetchCount); end
        #1;
        reset = 1'b1;
        step();
    endtask

    task automatic test_stall();
        clear_inputs();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        n_tests++; if (bus.PCF !== 32'h10 || bus.InstrD !== 32'hE000_000C || bus.PcD !== 32'hC) begin n_fail++; $display("FAIL pre_stall got %h/%h/%h exp 10/E000000C/C", bus.PCF, bus.InstrD, bus.PcD); end
        bus.StallF = 1; bus.StallD = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++; if (bus.PCF !== 32'h10 || bus.InstrD !== 32'hE000_000C || bus.PcD !== 32'hC || bus.ValidD !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d got pcf %h instr %h pcd %h valid %b exp 10/E000000C/C/1", i, bus.PCF, bus.InstrD, bus.PcD, bus.ValidD); end
        end
        n_tests++; if (bus.StallCount !== (PERF ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL stall_count got %0d exp %0d", bus.StallCount, PERF ? 3 : 0); end
        clear_inputs();
        step();
        n_tests++; if (bus.PCF !== 32'h14 || bus.InstrD !== 32'hE000_0010 || bus.PcD !== 32'h10 || bus.PcPlus8D !== 32'h18) begin n_fail++; $display("FAIL stall_release got %h/%h/%h/%h exp 14/E0000010/10/18", bus.PCF, bus.InstrD, bus.PcD, bus.PcPlus8D); end
        n_tests++; if (bus.FetchCount !== (PERF ? 32'd5 : 32'd0)) begin n_fail++; $display("FAIL fetch_count5 got %0d exp %0d", bus.FetchCount, PERF ? 5 : 0); end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 3; i++) step();
        n_tests++; if (bus.PCF !== 32'h20) begin n_fail++; $display("FAIL pre_branch got %h exp 20", bus.PCF); end
        bus.BranchTakenE = 1; bus.BranchTargetE = 32'h103;
        step();
        n_tests++; if (bus.PCF !== 32'h100) begin n_fail++; $display("FAIL br_pcf got %h exp 100", bus.PCF); end
        n_tests++; if (bus.ValidD !== 1'b0 || bus.InstrD !== 32'h0) begin n_fail++; $display("FAIL br_bubble got valid %b instr %h exp 0/0", bus.ValidD, bus.InstrD); end
        n_tests++; if (bus.PcD !== 32'h1C || bus.PcPlus8D !== 32'h24) begin n_fail++; $display("FAIL br_pcd_hold got %h/%h exp 1C/24", bus.PcD, bus.PcPlus8D); end
        clear_inputs();
        step();
        n_tests++; if (bus.PcD !== 32'h100 || bus.PcPlus8D !== 32'h108 || bus.ValidD !== 1'b1) begin n_fail++; $display("FAIL br_target got %h/%h/%b exp 100/108/1", bus.PcD, bus.PcPlus8D, bus.ValidD); end
        n_tests++; if (bus.InstrD !== 32'hE000_0100 || bus.PCF !== 32'h104) begin n_fail++; $display("FAIL br_next got instr %h pcf %h exp E0000100/104", bus.InstrD, bus.PCF); end
        n_tests++; if (bus.FetchCount !== (PERF ? 32'd9 : 32'd0)) begin n_fail++; $display("FAIL fetch_count9 got %0d exp %0d", bus.FetchCount, PERF ? 9 : 0); end
    endtask

    task automatic test_redirect_stall();
        bus.StallF = 1; bus.StallD = 1; bus.BranchTakenE = 1; bus.BranchTargetE = 32'h200;
        step();
        n_tests++; if (bus.PCF !== 32'h200) begin n_fail++; $display("FAIL rs_pcf got %h exp 200", bus.PCF); end
        n_tests++; if (bus.ValidD !== 1'b0 || bus.InstrD !== 32'h0 || bus.PcD !== 32'h100) begin n_fail++; $display("FAIL rs_bubble got %b/%h/%h exp 0/0/100", bus.ValidD, bus.InstrD, bus.PcD); end
        n_tests++; if (bus.StallCount !== (PERF ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL rs_stall_count got %0d exp %0d", bus.StallCount, PERF ? 3 : 0); end
        clear_inputs();
        step();
        n_tests++; if (bus.PCF !== 32'h204 || bus.PcD !== 32'h200 || bus.ValidD !== 1'b1) begin n_fail++; $display("FAIL rs_after got %h/%h/%b exp 204/200/1", bus.PCF, bus.PcD, bus.ValidD); end
    endtask

    task automatic test_flush();
        bus.FlushD = 1; bus.StallD = 1;
        step();
        n_tests++; if (bus.PCF !== 32'h208) begin n_fail++; $display("FAIL fl_pcf got %h exp 208", bus.PCF); end
        n_tests++; if (bus.ValidD !== 1'b0 || bus.InstrD !== 32'h0 || bus.PcD !== 32'h200 || bus.PcPlus8D !== 32'h208) begin n_fail++; $display("FAIL fl_bubble got %b/%h/%h/%h exp 0/0/200/208", bus.ValidD, bus.InstrD, bus.PcD, bus.PcPlus8D); end
        clear_inputs();
        step();
        n_tests++; if (bus.PCF !== 32'h20C || bus.PcD !== 32'h208 || bus.InstrD !== 32'hE000_0208 || bus.ValidD !== 1'b1) begin n_fail++; $display("FAIL fl_after got %h/%h/%h/%b exp 20C/208/E0000208/1", bus.PCF, bus.PcD, bus.InstrD, bus.ValidD); end
        n_tests++; if (bus.FetchCount !== (PERF ? 32'd11 : 32'd0)) begin n_fail++; $display("FAIL fetch_count11 got %0d exp %0d", bus.FetchCount, PERF ? 11 : 0); end
    endtask

    task automatic test_stallf_only();
        bus.StallF = 1;
        step();
        n_tests++; if (bus.PCF !== 32'h20C || bus.PcD !== 32'h20C || bus.InstrD !== 32'hE000_020C || bus.ValidD !== 1'b1) begin n_fail++; $display("FAIL sf_dup got %h/%h/%h/%b exp 20C/20C/E000020C/1", bus.PCF, bus.PcD, bus.InstrD, bus.ValidD); end
        n_tests++; if (bus.StallCount !== (PERF ? 32'd4 : 32'd0) || bus.FetchCount !== (PERF ? 32'd12 : 32'd0)) begin n_fail++; $display("FAIL sf_counts got %0d/%0d exp %0d/%0d", bus.StallCount, bus.FetchCount, PERF ? 4 : 0, PERF ? 12 : 0); end
        clear_inputs();
        step();
        n_tests++; if (bus.PCF !== 32'h210 || bus.PcD !== 32'h20C) begin n_fail++; $display("FAIL sf_after got %h/%h exp 210/20C", bus.PCF, bus.PcD); end
    endtask

    task automatic test_wrap();
        n_tests++; if (bus2.PCF !== 32'hFFFF_FFF8 || bus2.ValidD !== 1'b0) begin n_fail++; $display("FAIL wrap_rst got %h/%b exp FFFFFFF8/0", bus2.PCF, bus2.ValidD); end
        rst2_n = 1'b1;
        step();
        n_tests++; if (bus2.PCF !== 32'hFFFF_FFFC || bus2.PcD !== 32'hFFFF_FFF8 || bus2.PcPlus8D !== 32'h0 || bus2.InstrD !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap1 got %h/%h/%h/%h exp FFFFFFFC/FFFFFFF8/0/FFFFFFF8", bus2.PCF, bus2.PcD, bus2.PcPlus8D, bus2.InstrD); end
        step();
        n_tests++; if (bus2.PCF !== 32'h0 || bus2.PcD !== 32'hFFFF_FFFC || bus2.PcPlus8D !== 32'h4 || bus2.InstrD !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap2 got %h/%h/%h/%h exp 0/FFFFFFFC/4/FFFFFFFC", bus2.PCF, bus2.PcD, bus2.PcPlus8D, bus2.InstrD); end
        step();
        n_tests++; if (bus2.PCF !== 32'h4 || bus2.PcD !== 32'h0 || bus2.PcPlus8D !== 32'h8 || bus2.InstrD !== 32'hE000_0000) begin n_fail++; $display("FAIL wrap3 got %h/%h/%h/%h exp 4/0/8/E0000000", bus2.PCF, bus2.PcD, bus2.PcPlus8D, bus2.InstrD); end
    endtask

    task automatic test_saturation();
`ifdef FETCH_PERF_CNT_EN
        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        step();
        release dut.fetch_cnt_q;
        release dut.stall_cnt_q;
        bus.StallF = 1;
        step();
        step();
        clear_inputs();
        n_tests++; if (bus.FetchCount !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_fetch got %h exp FFFFFFFF", bus.FetchCount); end
        n_tests++; if (bus.StallCount !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_stall got %h exp FFFFFFFF", bus.StallCount); end
`else
        bus.StallF = 1;
        step();
        step();
        clear_inputs();
        n_tests++; if (bus.FetchCount !== 32'h0) begin n_fail++; $display("FAIL cnt_off_fetch got %h exp 0", bus.FetchCount); end
        n_tests++; if (bus.StallCount !== 32'h0) begin n_fail++; $display("FAIL cnt_off_stall got %h exp 0", bus.StallCount); end
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        rst2_n  = 1'b0;
        clear_inputs();
        bus2.StallF = 0; bus2.StallD = 0; bus2.FlushD = 0;
        bus2.BranchTakenE = 0; bus2.BranchTargetE = 32'h0;
        test_reset();
        test_async_reset();
        test_stall();
        test_branch();
        test_redirect_stall();
        test_flush();
        test_stallf_only();
        test_wrap();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
